// File: rtl/distribution_buffer_unit.sv
// distribution_buffer_unit: holds NUM_DIST distributions of DIST_WIDTH bits,
// loaded one WORD_WIDTH word at a time and returned through a word-serial,
// multicycle readout that stalls the core while it runs.
// Optional feature: define DU_BOUNDS_CHECK_EN to reject out-of-range slot and
// word indices (writes dropped, reads return zero) and report them on du_err.
module distribution_buffer_unit #(
    parameter int DIST_WIDTH = 256,
    parameter int WORD_WIDTH = 32,
    parameter int NUM_DIST   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  DUCtrl,
    input  logic                  du_wr_en,
    input  logic [WORD_WIDTH-1:0] du_wr_data,
    input  logic [31:0]           rs1,
    output logic [DIST_WIDTH-1:0] DU_result,
    output logic                  du_clk_stall,
    output logic                  du_valid,
    output logic                  du_err
);

    localparam int WORDS  = DIST_WIDTH / WORD_WIDTH;
    localparam int SLOT_W = (NUM_DIST > 1) ? $clog2(NUM_DIST) : 1;
    localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ     = 2'd1,
        DATA_OUT = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [WORD_WIDTH-1:0] mem_q [NUM_DIST][WORDS];
    logic [DIST_WIDTH-1:0] rdBuf_q;
    logic [DIST_WIDTH-1:0] result_q;
    logic [SLOT_W-1:0]     slot_q;
    logic [WIDX_W-1:0]     wordCnt_q;
    logic                  stall_q;
    logic                  valid_q;

    logic [SLOT_W-1:0]     reqSlot;
    logic [WIDX_W-1:0]     reqWord;
    logic                  wrAccept;
    logic                  unusedRs1;

    // Only the low slot/word index bits address storage; the rest of rs1 is don't-care.
    assign reqSlot   = rs1[SLOT_W-1:0];
    assign reqWord   = rs1[8 +: WIDX_W];
    assign unusedRs1 = ^rs1;

`ifdef DU_BOUNDS_CHECK_EN
    logic slotInRange;
    logic wordInRange;
    logic err_q;
    logic rdErr_q;

    assign slotInRange = {1'b0, rs1[7:0]}  < 9'(NUM_DIST);
    assign wordInRange = {1'b0, rs1[15:8]} < 9'(WORDS);
    assign wrAccept    = du_wr_en && slotInRange && wordInRange;
    assign du_err      = err_q;
`else
    assign wrAccept    = du_wr_en;
    assign du_err      = 1'b0;
`endif

    assign DU_result    = result_q;
    assign du_clk_stall = stall_q;
    assign du_valid     = valid_q;

    // State register for the readout sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> READ on request, READ until the last word, then one DATA_OUT cycle.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:     state_d = DUCtrl ? READ : IDLE;
            READ:     state_d = (wordCnt_q == LAST_WORD) ? DATA_OUT : READ;
            DATA_OUT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Datapath: slot storage, word-serial readout buffer and the registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NUM_DIST; s++) begin
                for (int w = 0; w < WORDS; w++) begin
                    mem_q[s][w] <= '0;
                end
            end
            rdBuf_q   <= '0;
            result_q  <= '0;
            slot_q    <= '0;
            wordCnt_q <= '0;
            stall_q   <= 1'b0;
            valid_q   <= 1'b0;
`ifdef DU_BOUNDS_CHECK_EN
            err_q     <= 1'b0;
            rdErr_q   <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
`ifdef DU_BOUNDS_CHECK_EN
            err_q   <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (wrAccept) begin
                        mem_q[reqSlot][reqWord] <= du_wr_data;
                    end
`ifdef DU_BOUNDS_CHECK_EN
                    if (du_wr_en && !(slotInRange && wordInRange)) begin
                        err_q <= 1'b1;
                    end
`endif
                    if (DUCtrl) begin
                        slot_q    <= reqSlot;
                        wordCnt_q <= '0;
                        stall_q   <= 1'b1;
`ifdef DU_BOUNDS_CHECK_EN
                        rdErr_q   <= !slotInRange;
`endif
                    end
                end
                READ: begin
                    rdBuf_q[wordCnt_q*WORD_WIDTH +: WORD_WIDTH] <= mem_q[slot_q][wordCnt_q];
                    wordCnt_q <= wordCnt_q + 1'b1;
                end
                DATA_OUT: begin
`ifdef DU_BOUNDS_CHECK_EN
                    result_q <= rdErr_q ? '0 : rdBuf_q;
                    err_q    <= rdErr_q;
`else
                    result_q <= rdBuf_q;
`endif
                    valid_q  <= 1'b1;
                    stall_q  <= 1'b0;
                end
                default: begin
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_distribution_buffer_unit.sv
// tb_distribution_buffer_unit: directed scoreboard bench for distribution_buffer_unit
// at default parameters (4 slots of 8 x 32-bit words).
module tb_distribution_buffer_unit;

    localparam int DW = 256;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } expT;

    logic          clk = 1'b0;
    logic          reset;
    logic          DUCtrl;
    logic          du_wr_en;
    logic [31:0]   du_wr_data;
    logic [31:0]   rs1;
    logic [DW-1:0] DU_result;
    logic          du_clk_stall;
    logic          du_valid;
    logic          du_err;

    expT expQ[$];
    int  testsRun       = 0;
    int  failCount      = 0;
    int  validCount     = 0;
    int  expectedValids = 0;

    localparam logic [DW-1:0] SLOT2_PATTERN =
        256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;

    distribution_buffer_unit dut (
        .clk          (clk),
        .reset        (reset),
        .DUCtrl       (DUCtrl),
        .du_wr_en     (du_wr_en),
        .du_wr_data   (du_wr_data),
        .rs1          (rs1),
        .DU_result    (DU_result),
        .du_clk_stall (du_clk_stall),
        .du_valid     (du_valid),
        .du_err       (du_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drive one request for a single clock edge, then return 1 time unit after that edge.
    task automatic applyStimulus(input logic ctrl, input logic wrEn, input logic [7:0] slot,
                                 input logic [7:0] word, input logic [31:0] data);
        DUCtrl     = ctrl;
        du_wr_en   = wrEn;
        rs1        = {16'h0, word, slot};
        du_wr_data = data;
        @(posedge clk);
        #1;
        DUCtrl   = 1'b0;
        du_wr_en = 1'b0;
    endtask

    task automatic writeWord(input logic [7:0] slot, input logic [7:0] word,
                             input logic [31:0] data, input logic expErr);
        applyStimulus(1'b0, 1'b1, slot, word, data);
        @(negedge clk);
        checkOutput("wr_err", DW'(du_err), DW'(expErr));
        checkOutput("wr_nostall", DW'(du_clk_stall), DW'(0));
    endtask

    // Issue a read (optionally with a simultaneous write), count stall cycles, and
    // optionally inject illegal DUCtrl/du_wr_en traffic at stall cycle injectAt.
    task automatic doRead(input logic [7:0] slot, input logic [DW-1:0] expData,
                          input logic expErr, input int injectAt, input logic wrEn,
                          input logic [7:0] word, input logic [31:0] data);
        expT e;
        int  stallCycles;
        e.data = expData;
        e.err  = expErr;
        expQ.push_back(e);
        expectedValids++;
        applyStimulus(1'b1, wrEn, slot, word, data);
        stallCycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == injectAt) begin
                DUCtrl     = 1'b1;
                du_wr_en   = 1'b1;
                rs1        = 32'h0;
                du_wr_data = 32'hFFFF_FFFF;
            end else if (i == injectAt + 1) begin
                DUCtrl   = 1'b0;
                du_wr_en = 1'b0;
            end
            if (du_clk_stall) stallCycles++;
            else break;
        end
        DUCtrl   = 1'b0;
        du_wr_en = 1'b0;
        checkOutput("stall_cycles", DW'(stallCycles), DW'(9));
        @(posedge clk);
        #1;
    endtask

    // Monitor: every du_valid pulse consumes one expected response from the scoreboard.
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (!reset && du_valid) begin
                validCount++;
                if (expQ.size() == 0) begin
                    testsRun++;
                    failCount++;
                    $display("[TB] FAIL unexpected_valid: got result %0h with no read pending", DU_result);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("read_result", DU_result, e.data);
                    checkOutput("read_err", DW'(du_err), DW'(e.err));
                end
            end
        end
    end

    // Directed sequence.
    initial begin
        reset      = 1'b1;
        DUCtrl     = 1'b0;
        du_wr_en   = 1'b0;
        du_wr_data = 32'h0;
        rs1        = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        checkOutput("rst_result", DU_result, '0);
        checkOutput("rst_stall", DW'(du_clk_stall), DW'(0));
        checkOutput("rst_valid", DW'(du_valid), DW'(0));
        checkOutput("rst_err", DW'(du_err), DW'(0));

        doRead(8'd0, '0, 1'b0, -1, 1'b0, 8'd0, 32'h0);

        for (int k = 0; k < 8; k++) begin
            writeWord(8'd2, 8'(k), 32'h1111_1111 * (k + 1), 1'b0);
        end
        doRead(8'd2, SLOT2_PATTERN, 1'b0, -1, 1'b0, 8'd0, 32'h0);
        doRead(8'd0, '0, 1'b0, -1, 1'b0, 8'd0, 32'h0);
        doRead(8'd1, '0, 1'b0, -1, 1'b0, 8'd0, 32'h0);
        doRead(8'd3, '0, 1'b0, -1, 1'b0, 8'd0, 32'h0);

`ifdef DU_BOUNDS_CHECK_EN
        writeWord(8'd5, 8'd0, 32'hCAFE_F00D, 1'b1);
        doRead(8'd1, '0, 1'b0, -1, 1'b0, 8'd0, 32'h0);
        doRead(8'd7, '0, 1'b1, -1, 1'b0, 8'd0, 32'h0);
`else
        doRead(8'd6, SLOT2_PATTERN, 1'b0, -1, 1'b0, 8'd0, 32'h0);
`endif

        doRead(8'd1, {128'h0, 32'hDEAD_BEEF, 96'h0}, 1'b0, -1, 1'b1, 8'd3, 32'hDEAD_BEEF);

        writeWord(8'd0, 8'd0, 32'hA5A5_A5A5, 1'b0);
        doRead(8'd0, {224'h0, 32'hA5A5_A5A5}, 1'b0, 3, 1'b0, 8'd0, 32'h0);
        doRead(8'd0, {224'h0, 32'hA5A5_A5A5}, 1'b0, -1, 1'b0, 8'd0, 32'h0);

        applyStimulus(1'b1, 1'b0, 8'd2, 8'd0, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("rst_mid_result", DU_result, '0);
        checkOutput("rst_mid_stall", DW'(du_clk_stall), DW'(0));
        checkOutput("rst_mid_valid", DW'(du_valid), DW'(0));
        doRead(8'd2, '0, 1'b0, -1, 1'b0, 8'd0, 32'h0);

        repeat (3) @(negedge clk);
        checkOutput("valid_count", DW'(validCount), DW'(expectedValids));
        checkOutput("queue_empty", DW'(expQ.size()), DW'(0));

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/distribution_buffer_unit.md
# distribution_buffer_unit

Parametrised, multi-slot successor to the single-distribution unit. Holds NUM_DIST distributions of DIST_WIDTH bits each, loaded one WORD_WIDTH word at a time by the core. On request it returns the selected slot as a full-width result through a multicycle, word-serial readout that stalls the pipeline. It sits beside the ALU in the execute stage, driven by the DU control line and rs1.

## Interface
- DIST_WIDTH, 256, bits per distribution; must be a multiple of WORD_WIDTH.
- WORD_WIDTH, 32, bits per load word and per readout step.
- NUM_DIST, 4, number of distribution slots; power of two, 1..256.
- Derived: WORDS = DIST_WIDTH/WORD_WIDTH (1..256); SLOT_W = max(1, clog2(NUM_DIST)); WIDX_W = max(1, clog2(WORDS)).
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- DUCtrl  in  1  read request for slot rs1[7:0]; sampled only in IDLE.
- du_wr_en  in  1  write request: du_wr_data goes to word rs1[15:8] of slot rs1[7:0]; sampled only in IDLE.
- du_wr_data  in  WORD_WIDTH  load word.
- rs1  in  32  index operand. [7:0] is the slot; [15:8] is the word (writes only); other bits are ignored.
- DU_result  out  DIST_WIDTH  last returned distribution; held until the next completion.
- du_clk_stall  out  1  high while a read is in flight.
- du_valid  out  1  one-cycle pulse when DU_result updates.
- du_err  out  1  one-cycle index-error pulse (see Configuration).

## Operation
- **Reset** (any state, including mid-read):
  - state to IDLE; DU_result, du_clk_stall, du_valid, du_err and the read buffer to 0.
  - Word counter to 0; all slot storage cleared to 0.
- **States:** IDLE, READ, DATA_OUT. Any unencoded state returns to IDLE on the next edge.
- **IDLE:**
  - du_wr_en=1 writes du_wr_data into storage[slot][word] at the same edge. No stall.
  - Word w occupies bits [w*WORD_WIDTH +: WORD_WIDTH]; word 0 is the LSBs.
  - DUCtrl=1: latch the slot, clear the word counter, set du_clk_stall, go to READ.
  - Write and read together: the write commits at the same edge. The read therefore returns the newly written word.
- **READ:**
  - Each cycle, copy storage[slot] word[counter] into the same word position of the read buffer, then increment the counter.
  - After the word at index WORDS-1 is copied, go to DATA_OUT.
- **DATA_OUT:** DU_result <= read buffer; du_valid <= 1; du_clk_stall <= 0; go to IDLE.
- **Outside IDLE:** du_wr_en and DUCtrl are ignored (dropped, not queued). The core is stalled, so these are not legal traffic.
- du_valid and du_err deassert on the edge after they pulse.
- Storage writes are not visible to a read already in flight. No write can occur then.

## Timing
- DUCtrl sampled high at edge E0:
  - du_clk_stall is high from after E0 through edge E0+WORDS+1.
  - Word k is copied at edge E0+1+k.
  - DU_result and du_valid update at edge E0+WORDS+1.
- Read latency = WORDS+1 cycles (9 at defaults).
- Back-to-back reads: a new DUCtrl is accepted at the first IDLE edge, i.e. E0+WORDS+2 at the earliest.
- Write latency: 1 edge. A read issued at the next edge sees the write.
- DU_result is registered and never changes except at DATA_OUT or reset.

## Configuration
- **DU_BOUNDS_CHECK_EN defined:**
  - An index is out of range when slot ≥ NUM_DIST or, for writes, word ≥ WORDS.
  - Out-of-range write: dropped; du_err pulses at the next edge.
  - Out-of-range read: runs the normal latency but returns all-zero DU_result; du_err pulses together with du_valid.
- **Undefined:**
  - Slot is truncated to rs1[SLOT_W-1:0]; word is truncated to rs1[8 +: WIDX_W].
  - du_err is tied to 0.

## Test plan
- Reset, then read slot 0: DU_result=0 after 9 cycles; stall high exactly 9 cycles; du_valid pulses once.
- Write words 0..7 of slot 2 with 0x11111111*(k+1), then read slot 2: DU_result=0x8888…_1111 (word7…word0); slots 0, 1 and 3 still read 0.
- Write and DUCtrl in the same cycle to slot 1, word 3 = 0xDEADBEEF: the read returns 0xDEADBEEF in bits [127:96].
- During a read, pulse DUCtrl and du_wr_en (slot 0, 0xFFFFFFFF): no restart, no write; a later read of slot 0 returns the prior contents. Reset asserted mid-READ: all outputs 0 and state IDLE next cycle.
- With DU_BOUNDS_CHECK_EN: write to slot 5 → du_err pulse, storage unchanged; read of slot 7 → zero result with du_err alongside du_valid. Without it: read of slot 6 returns slot 2.
